hex_display_decoder: RTL and testbench



---
 rtl/hex_display_decoder_pkg.sv | 30 +++
 rtl/hex_display_decoder_seg_pattern_decode.sv | 39 +++
 rtl/hex_display_decoder.sv | 139 +++++++++++++
 tb/tb_hex_display_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_decoder_pkg.sv
// Shared 7-segment definitions for the HexDisplay/SevSeg encoder and the readback decoder.
// Patterns are stored active-low, bit order {g,f,e,d,c,b,a}.
package hex_display_pkg;

  typedef logic [6:0] seg_t;

  localparam int NUM_DIGITS = 4;

  // All segments dark; only legal when leading-zero blanking is enabled.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Index n holds the active-low pattern that displays hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    DONE
  } state_t;

  function automatic seg_t seg_encode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_display_decoder_seg_pattern_decode.sv
// Combinational 7-segment pattern to nibble lookup with a legality flag.
// Build option HEX_DISPLAY_DECODER_BLANK_EN: the all-dark pattern decodes as a legal 0.
module seg_pattern_decode
  import hex_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  seg_t       seg,
  output logic [3:0] nibble,
  output logic       valid
);

`ifdef HEX_DISPLAY_DECODER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  seg_t w_pattern;

  // Normalise to the active-low form the table is written in.
  assign w_pattern = SEG_ACTIVE_LOW ? seg : ~seg;

  always_comb begin
    nibble = 4'h0;
    valid  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (w_pattern == SEG_TABLE[i]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
    if (BLANK_EN && (w_pattern == SEG_BLANK)) begin
      nibble = 4'h0;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_decoder.sv
// Reconstructs a 16-bit value from four 7-segment digit patterns, one digit per clock.
// Build option HEX_DISPLAY_DECODER_BLANK_EN is honoured by the shared pattern decoder.
module hex_display_decoder
  import hex_display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  DIG0,
  input  logic [6:0]  DIG1,
  input  logic [6:0]  DIG2,
  input  logic [6:0]  DIG3,
  output logic [15:0] binary,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  err_mask
);

  state_t r_state;
  state_t w_nextState;

  logic [27:0] r_capture;
  logic [1:0]  r_cnt;
  logic [15:0] r_acc;
  logic [3:0]  r_maskAcc;
  logic [15:0] r_binary;
  logic [3:0]  r_errMask;
  logic        r_err;
  logic        r_done;

  logic        w_capture;
  logic        w_decode;
  logic        w_finish;
  logic        w_busy;
  seg_t        w_selSeg;
  logic [3:0]  w_nibble;
  logic        w_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Start is only honoured from IDLE, so requests during DECODE or DONE are dropped.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_decode    = 1'b0;
    w_finish    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_nextState = DECODE;
        end
      end
      DECODE: begin
        w_busy   = 1'b1;
        w_decode = 1'b1;
        if (r_cnt == 2'd0) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_busy      = 1'b1;
        w_finish    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    w_selSeg = r_capture[6:0];
    case (r_cnt)
      2'd3:    w_selSeg = r_capture[27:21];
      2'd2:    w_selSeg = r_capture[20:14];
      2'd1:    w_selSeg = r_capture[13:7];
      default: w_selSeg = r_capture[6:0];
    endcase
  end

  seg_pattern_decode #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_segDecode (
    .seg    (w_selSeg),
    .nibble (w_nibble),
    .valid  (w_valid)
  );

  // Most significant digit is decoded first so each nibble shifts in from the right.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_capture <= '0;
      r_cnt     <= 2'd0;
      r_acc     <= 16'h0000;
      r_maskAcc <= 4'h0;
      r_binary  <= 16'h0000;
      r_errMask <= 4'h0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_capture <= {DIG3, DIG2, DIG1, DIG0};
        r_acc     <= 16'h0000;
        r_maskAcc <= 4'h0;
        r_cnt     <= 2'd3;
      end
      if (w_decode) begin
        r_acc          <= {r_acc[11:0], (w_valid ? w_nibble : 4'h0)};
        r_maskAcc[r_cnt] <= ~w_valid;
        r_cnt          <= r_cnt - 2'd1;
      end
      if (w_finish) begin
        r_binary  <= r_acc;
        r_errMask <= r_maskAcc;
        r_err     <= |r_maskAcc;
        r_done    <= 1'b1;
      end
    end
  end

  assign binary   = r_binary;
  assign busy     = w_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign err_mask = r_errMask;

endmodule

// File: tb/tb_hex_display_decoder.sv
// Directed bench for hex_display_decoder: table of digit sets, encoder loopback,
// busy/reset corner cases, and an active-high twin fed with inverted segments.
module tb_hex_display_decoder;

`ifdef HEX_DISPLAY_DECODER_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  dig0, dig1, dig2, dig3;
  logic [6:0]  digHi0, digHi1, digHi2, digHi3;
  logic [15:0] binary, binaryHi;
  logic        busy, busyHi, done, doneHi, err, errHi;
  logic [3:0]  errMask, errMaskHi;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string       name;
    logic [6:0]  d3, d2, d1, d0;
    logic [15:0] expBin;
    logic [3:0]  expMask;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  assign digHi0 = ~dig0;
  assign digHi1 = ~dig1;
  assign digHi2 = ~dig2;
  assign digHi3 = ~dig3;

  hex_display_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .DIG0(dig0), .DIG1(dig1), .DIG2(dig2), .DIG3(dig3),
    .binary(binary), .busy(busy), .done(done), .err(err), .err_mask(errMask)
  );

  hex_display_decoder #(.SEG_ACTIVE_LOW(1'b0)) dutHi (
    .clk(clk), .reset(reset), .start(start),
    .DIG0(digHi0), .DIG1(digHi1), .DIG2(digHi2), .DIG3(digHi3),
    .binary(binaryHi), .busy(busyHi), .done(doneHi), .err(errHi), .err_mask(errMaskHi)
  );

  function automatic logic [6:0] encodeNibble(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives the digits and a one-cycle start; returns #1 after the capturing edge.
  task automatic applyStimulus(input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0);
    @(negedge clk);
    dig3 = d3; dig2 = d2; dig1 = d1; dig0 = d0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic runConversion(input string name, input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0,
                               input logic [15:0] expBin, input logic [3:0] expMask);
    int cycles;
    applyStimulus(d3, d2, d1, d0);
    checkOutput({name, " busy"}, 32'(busy), 32'd1);
    cycles = 0;
    do begin
      @(posedge clk);
      #1 cycles++;
    end while (!done && cycles < 20);
    checkOutput({name, " latency"}, 32'(cycles), 32'd5);
    checkOutput({name, " binary"}, 32'(binary), 32'(expBin));
    checkOutput({name, " err_mask"}, 32'(errMask), 32'(expMask));
    checkOutput({name, " err"}, 32'(err), 32'(|expMask));
    checkOutput({name, " hi done"}, 32'(doneHi), 32'd1);
    checkOutput({name, " hi binary"}, 32'(binaryHi), 32'(expBin));
    checkOutput({name, " hi err_mask"}, 32'(errMaskHi), 32'(expMask));
    @(posedge clk);
    #1;
    checkOutput({name, " done pulse"}, 32'({done, busy}), 32'd0);
  endtask

  initial begin
    logic [15:0] val;
    int doneCount;
    int doneEdge;

    reset = 1'b1;
    start = 1'b0;
    dig0 = 7'h00; dig1 = 7'h00; dig2 = 7'h00; dig3 = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs", {binary, busy, done, err, errMask}, 32'd0);
    checkOutput("reset outputs hi", {binaryHi, busyHi, doneHi, errHi, errMaskHi}, 32'd0);
    reset = 1'b0;

    vecs[0] = '{"sweep",      7'h79, 7'h08, 7'h24, 7'h0E, 16'h1A2F, 4'b0000};
    vecs[1] = '{"blank dig2", 7'h30, 7'h7F, 7'h12, 7'h10, 16'h3059, (BLANK ? 4'b0000 : 4'b0100)};
    vecs[2] = '{"one",        7'h40, 7'h40, 7'h40, 7'h79, 16'h0001, 4'b0000};
    vecs[3] = '{"all F",      7'h0E, 7'h0E, 7'h0E, 7'h0E, 16'hFFFF, 4'b0000};
    vecs[4] = '{"bad dig0",   7'h19, 7'h02, 7'h78, 7'h01, 16'h4670, 4'b0001};
    vecs[5] = '{"mixed bad",  7'h7F, 7'h03, 7'h46, 7'h55, 16'h0BC0, (BLANK ? 4'b0001 : 4'b1001)};
    vecs[6] = '{"8DE0",       7'h00, 7'h21, 7'h06, 7'h40, 16'h8DE0, 4'b0000};

    for (int i = 0; i < 7; i++) begin
      runConversion(vecs[i].name, vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0,
                    vecs[i].expBin, vecs[i].expMask);
    end

    for (int i = 0; i < 103; i++) begin
      case (i)
        0:       val = 16'h0000;
        1:       val = 16'hFFFF;
        2:       val = 16'h8001;
        default: val = 16'($urandom_range(0, 65535));
      endcase
      runConversion("loopback", encodeNibble(val[15:12]), encodeNibble(val[11:8]),
                    encodeNibble(val[7:4]), encodeNibble(val[3:0]), val, 4'b0000);
    end

    // Restarts two edges in and again in the DONE cycle must both be dropped.
    applyStimulus(7'h79, 7'h08, 7'h24, 7'h0E);
    doneCount = 0;
    doneEdge  = 0;
    for (int j = 1; j <= 14; j++) begin
      start = (j == 2 || j == 5);
      if (j == 2) begin
        dig3 = 7'h12; dig2 = 7'h12; dig1 = 7'h12; dig0 = 7'h12;
      end
      if (j == 3) begin
        dig3 = 7'h55; dig2 = 7'h40; dig1 = 7'h00; dig0 = 7'h79;
      end
      @(posedge clk);
      #1;
      if (done) begin
        doneCount++;
        if (doneEdge == 0) doneEdge = j;
      end
    end
    start = 1'b0;
    checkOutput("busy protocol done count", 32'(doneCount), 32'd1);
    checkOutput("busy protocol done edge", 32'(doneEdge), 32'd5);
    checkOutput("busy protocol binary", 32'(binary), 32'h1A2F);
    checkOutput("busy protocol err_mask", 32'(errMask), 32'd0);

    runConversion("pre-reset", 7'h19, 7'h02, 7'h78, 7'h01, 16'h4670, 4'b0001);
    applyStimulus(7'h0E, 7'h0E, 7'h0E, 7'h0E);
    @(posedge clk);
    #1;
    checkOutput("hold binary", 32'(binary), 32'h4670);
    checkOutput("hold err_mask", 32'({err, errMask}), 32'h11);
    reset = 1'b1;
    #1;
    checkOutput("mid reset outputs", {binary, busy, done, err, errMask}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    doneCount = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (done || doneHi) doneCount++;
    end
    checkOutput("no done after reset", 32'(doneCount), 32'd0);
    runConversion("restart", 7'h40, 7'h40, 7'h40, 7'h79, 16'h0001, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
